// File: rtl/mem_stage_unit.sv
// ---------------------------------------------------------------------------
// mem_stage_unit
//
// Memory stage of the pipelined CPU. Consumes the EX/M latch outputs, issues
// data-cache loads/stores, stalls the front of the pipe until the cache
// reports dhit, maintains the LL/SC link register (with coherence snoop
// invalidation), selects the write-back data and drives the M/WB latch.
// Also holds a sticky HALT and a saturating count of memory-stall cycles.
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   dREN_in / dWEN_in        EX/M load / store request
//   dmemStore                EX/M store data
//   portO_in                 EX/M ALU result (memory address or ALU WB data)
//   MemtoReg_in              WB data comes from memory
//   wdatasrc_in, pcp4_in     WB data is PC+4 (JAL)
//   WSel_in, WEN_in          destination register and its write enable
//   HALT_in                  halt instruction in this stage
//   opcode_in                opcode of the instruction in this stage
//   flush                    kill the instruction in this stage
//   dhit, dmemload           cache completion and load data
//   ccinv, ccsnoopaddr       coherence invalidate and snooped address
//   dmemREN/dmemWEN          cache read / write request
//   dmemaddr, dmemstore      cache word address and store data
//   m_stall                  freeze PC, IF/ID, ID/EX, EX/M
//   WSel_out/WEN_out/wdat_out M/WB latch
//   HALT_out                 sticky halt
//   stall_cnt                number of cycles m_stall was high (saturating)
// ---------------------------------------------------------------------------
module mem_stage_unit #(
    parameter bit          LINK_CLR_ON_ST = 1'b1,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             dREN_in,
    input  logic             dWEN_in,
    input  logic [31:0]      dmemStore,
    input  logic [31:0]      portO_in,
    input  logic             MemtoReg_in,
    input  logic             wdatasrc_in,
    input  logic [31:0]      pcp4_in,
    input  logic [4:0]       WSel_in,
    input  logic             WEN_in,
    input  logic             HALT_in,
    input  logic [5:0]       opcode_in,
    input  logic             flush,
    input  logic             dhit,
    input  logic [31:0]      dmemload,
    input  logic             ccinv,
    input  logic [31:0]      ccsnoopaddr,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic [31:0]      dmemaddr,
    output logic [31:0]      dmemstore,
    output logic             m_stall,
    output logic [4:0]       WSel_out,
    output logic             WEN_out,
    output logic [31:0]      wdat_out,
    output logic             HALT_out,
    output logic [CNT_W-1:0] stall_cnt
);

    // Opcodes this stage has to recognise (MIPS encoding).
    localparam logic [5:0] OP_SW = 6'b101011;
    localparam logic [5:0] OP_LL = 6'b110000;
    localparam logic [5:0] OP_SC = 6'b111000;

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_HALTED
    } state_t;

    state_t           state_q, state_d;
    logic             link_valid_q, link_valid_d;
    logic [31:0]      link_addr_q, link_addr_d;
    logic [4:0]       wsel_q, wsel_d;
    logic             wen_q, wen_d;
    logic [31:0]      wdat_q, wdat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // -----------------------------------------------------------------------
    // Decode of the instruction sitting in the EX/M latch
    // -----------------------------------------------------------------------
    logic        is_sw, is_ll, is_sc;
    logic [31:0] word_addr;
    logic        link_match;
    logic        sc_fail;
    logic        mem_op;

    assign is_sw      = (opcode_in == OP_SW);
    assign is_ll      = (opcode_in == OP_LL);
    assign is_sc      = (opcode_in == OP_SC);
    assign word_addr  = portO_in & WORD_MASK;
    assign link_match = link_valid_q && (word_addr == link_addr_q);
    // A failing SC never reaches the cache; it just writes 0 to rt.
    assign sc_fail    = is_sc && !link_match;
    assign mem_op     = (dREN_in || dWEN_in) && !flush && !sc_fail;

    // -----------------------------------------------------------------------
    // Next-state / output logic
    // -----------------------------------------------------------------------
    logic req;       // cache request presented this cycle
    logic wb_load;   // M/WB latch takes a new instruction at the next edge
    logic wb_wen;    // write enable that goes with it
    logic complete;  // cache access finishes this cycle

    // NOTE: every signal assigned in this block gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        wb_load = 1'b0;
        wb_wen  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (mem_op) begin
                    // Request goes out the cycle the op arrives; a hit in
                    // that same cycle completes with no stall at all.
                    req = 1'b1;
                    if (dhit) begin
                        wb_load = 1'b1;
                        wb_wen  = WEN_in;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end else if (HALT_in && !flush) begin
                    state_d = ST_HALTED;
                end else begin
                    // ALU/JAL ops, failed SCs and flushed bubbles.
                    wb_load = 1'b1;
                    wb_wen  = WEN_in && !flush;
                end
            end

            ST_ACCESS: begin
                // EX/M is frozen by m_stall, so its outputs still describe
                // the op in flight. A flush only aborts if dhit is low; the
                // request itself drops at the next edge.
                req = 1'b1;
                if (dhit) begin
                    wb_load = 1'b1;
                    wb_wen  = WEN_in;
                    state_d = ST_IDLE;
                end else if (flush) begin
                    state_d = ST_IDLE;
                end
            end

            ST_HALTED: begin
                state_d = ST_HALTED;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reset overrides everything, including a request in progress.
        if (RST) begin
            req     = 1'b0;
            wb_load = 1'b0;
            wb_wen  = 1'b0;
        end
    end

    assign complete  = req && dhit;
    assign m_stall   = req && !dhit;

    assign dmemREN   = req && dREN_in;
    assign dmemWEN   = req && dWEN_in;
    assign dmemaddr  = req ? word_addr : 32'd0;
    assign dmemstore = req ? dmemStore : 32'd0;

    // -----------------------------------------------------------------------
    // M/WB latch next state
    // -----------------------------------------------------------------------
    always_comb begin
        wsel_d = wsel_q;
        wdat_d = wdat_q;
        wen_d  = 1'b0;   // bubble unless a new instruction is latched
        if (wb_load) begin
            wsel_d = WSel_in;
            wen_d  = wb_wen;
            if (is_sc) begin
                // Success only if the store actually went to the cache.
                wdat_d = {31'd0, req};
            end else if (MemtoReg_in) begin
                wdat_d = dmemload;
            end else if (wdatasrc_in) begin
                wdat_d = pcp4_in;
            end else begin
                wdat_d = portO_in;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Link register next state. Later assignments take priority, so an LL
    // completing in the same cycle as a matching snoop leaves the link set.
    // -----------------------------------------------------------------------
    always_comb begin
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;

        // Any SC that retires (successful store or local failure) consumes
        // the link.
        if (is_sc && (complete || (wb_load && !flush))) begin
            link_valid_d = 1'b0;
        end
        if (LINK_CLR_ON_ST && complete && is_sw && (word_addr == link_addr_q)) begin
            link_valid_d = 1'b0;
        end
        if (ccinv && ((ccsnoopaddr & WORD_MASK) == link_addr_q)) begin
            link_valid_d = 1'b0;
        end
        if (complete && is_ll) begin
            link_valid_d = 1'b1;
            link_addr_d  = word_addr;
        end
    end

    // -----------------------------------------------------------------------
    // Stall counter (saturating)
    // -----------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q;
        if (m_stall && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            link_valid_q <= 1'b0;
            link_addr_q  <= 32'd0;
            wsel_q       <= 5'd0;
            wen_q        <= 1'b0;
            wdat_q       <= 32'd0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
            wsel_q       <= wsel_d;
            wen_q        <= wen_d;
            wdat_q       <= wdat_d;
            cnt_q        <= cnt_d;
        end
    end

    assign WSel_out  = wsel_q;
    assign WEN_out   = wen_q;
    assign wdat_out  = wdat_q;
    assign HALT_out  = (state_q == ST_HALTED);
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_mem_stage_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_unit
//
// Directed-vector bench for mem_stage_unit. Each expected M/WB register write
// is pushed into a queue when its instruction is issued; a monitor on the
// falling edge pops and compares every time WEN_out is high. Combinational
// request/stall outputs and the sticky/perf outputs are checked inline.
// ---------------------------------------------------------------------------
module tb_mem_stage_unit;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_LL  = 6'b110000;
    localparam logic [5:0] OP_SC  = 6'b111000;
    localparam logic [5:0] OP_ALU = 6'b000000;

    typedef struct packed {
        logic [4:0]  wsel;
        logic [31:0] wdat;
    } wb_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        dREN_in, dWEN_in;
    logic [31:0] dmemStore, portO_in, pcp4_in, dmemload, ccsnoopaddr;
    logic        MemtoReg_in, wdatasrc_in, WEN_in, HALT_in, flush, dhit, ccinv;
    logic [4:0]  WSel_in;
    logic [5:0]  opcode_in;
    logic        dmemREN, dmemWEN, m_stall, WEN_out, HALT_out;
    logic [31:0] dmemaddr, dmemstore, wdat_out;
    logic [4:0]  WSel_out;
    logic [31:0] stall_cnt;

    int  n_tests = 0;
    int  n_fail  = 0;
    wb_t exp_q[$];

    mem_stage_unit #(.LINK_CLR_ON_ST(1'b1), .CNT_W(32)) dut (
        .CLK(CLK), .RST(RST),
        .dREN_in(dREN_in), .dWEN_in(dWEN_in), .dmemStore(dmemStore),
        .portO_in(portO_in), .MemtoReg_in(MemtoReg_in), .wdatasrc_in(wdatasrc_in),
        .pcp4_in(pcp4_in), .WSel_in(WSel_in), .WEN_in(WEN_in), .HALT_in(HALT_in),
        .opcode_in(opcode_in), .flush(flush), .dhit(dhit), .dmemload(dmemload),
        .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .m_stall(m_stall), .WSel_out(WSel_out),
        .WEN_out(WEN_out), .wdat_out(wdat_out), .HALT_out(HALT_out),
        .stall_cnt(stall_cnt)
    );

    initial forever #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every register write must match the oldest
    // outstanding expectation.
    always @(negedge CLK) begin
        if (WEN_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected_write: got wsel=%0d wdat=0x%08h, expected no write",
                         WSel_out, wdat_out);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                check("sb_wsel", {27'd0, WSel_out}, {27'd0, e.wsel});
                check("sb_wdat", wdat_out, e.wdat);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr();
        dREN_in = 0; dWEN_in = 0; dmemStore = 0; portO_in = 0; pcp4_in = 0;
        MemtoReg_in = 0; wdatasrc_in = 0; WSel_in = 0; WEN_in = 0; HALT_in = 0;
        opcode_in = OP_ALU; flush = 0; dhit = 0; dmemload = 0; ccinv = 0;
        ccsnoopaddr = 0;
    endtask

    // Load-type op (LW/LL) into the EX/M inputs.
    task automatic set_load(input logic [5:0] op, input logic [31:0] addr,
                            input logic [4:0] rd, input logic [31:0] data, input logic hit);
        opcode_in = op; dREN_in = 1; portO_in = addr; MemtoReg_in = 1;
        WSel_in = rd; WEN_in = 1; dmemload = data; dhit = hit;
    endtask

    // Store-type op (SW/SC) into the EX/M inputs.
    task automatic set_store(input logic [5:0] op, input logic [31:0] addr,
                             input logic [31:0] data, input logic [4:0] rd,
                             input logic wen, input logic hit);
        opcode_in = op; dWEN_in = 1; portO_in = addr; dmemStore = data;
        WSel_in = rd; WEN_in = wen; dhit = hit;
    endtask

    initial begin
        clr();
        RST = 1;
        repeat (2) step();
        @(negedge CLK);
        check("rst_wen_out", {31'd0, WEN_out}, 32'd0);
        check("rst_halt_out", {31'd0, HALT_out}, 32'd0);
        check("rst_stall_cnt", stall_cnt, 32'd0);
        check("rst_wdat_out", wdat_out, 32'd0);
        check("rst_dmemREN", {31'd0, dmemREN}, 32'd0);
        RST = 0;
        step();

        // ALU op: one-cycle write of portO, no cache traffic.
        portO_in = 32'h10; WSel_in = 5'd3; WEN_in = 1;
        exp_q.push_back('{wsel: 5'd3, wdat: 32'h10});
        @(negedge CLK);
        check("alu_no_ren", {31'd0, dmemREN}, 32'd0);
        check("alu_no_stall", {31'd0, m_stall}, 32'd0);
        step(); clr();

        // JAL-style op: write PC+4.
        wdatasrc_in = 1; pcp4_in = 32'h0000_0404; portO_in = 32'h55; WSel_in = 5'd31; WEN_in = 1;
        exp_q.push_back('{wsel: 5'd31, wdat: 32'h0000_0404});
        step(); clr();

        // LW, unaligned address bits dropped, dhit after 3 stall cycles.
        set_load(OP_LW, 32'h103, 5'd4, 32'hDEAD_BEEF, 1'b0);
        exp_q.push_back('{wsel: 5'd4, wdat: 32'hDEAD_BEEF});
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("lw_stall", {31'd0, m_stall}, 32'd1);
            check("lw_ren", {31'd0, dmemREN}, 32'd1);
            check("lw_addr", dmemaddr, 32'h100);
            step();
        end
        dhit = 1;
        @(negedge CLK);
        check("lw_hit_nostall", {31'd0, m_stall}, 32'd0);
        step(); clr();
        @(negedge CLK);
        check("lw_stall_cnt", stall_cnt, 32'd3);
        check("lw_req_dropped", {31'd0, dmemREN}, 32'd0);

        // LL 0x200 (hit at entry), then SC 0x200 succeeds after one stall.
        step();
        set_load(OP_LL, 32'h200, 5'd5, 32'h7, 1'b1);
        exp_q.push_back('{wsel: 5'd5, wdat: 32'h7});
        @(negedge CLK);
        check("ll_zero_stall", {31'd0, m_stall}, 32'd0);
        step(); clr();
        set_store(OP_SC, 32'h200, 32'd5, 5'd6, 1'b1, 1'b0);
        exp_q.push_back('{wsel: 5'd6, wdat: 32'd1});
        @(negedge CLK);
        check("sc_ok_wen", {31'd0, dmemWEN}, 32'd1);
        check("sc_ok_data", dmemstore, 32'd5);
        check("sc_ok_stall", {31'd0, m_stall}, 32'd1);
        step();
        dhit = 1;
        @(negedge CLK);
        check("sc_ok_hit_wen", {31'd0, dmemWEN}, 32'd1);
        step(); clr();

        // Repeat SC: link consumed, fails locally with no request.
        set_store(OP_SC, 32'h200, 32'd5, 5'd6, 1'b1, 1'b0);
        exp_q.push_back('{wsel: 5'd6, wdat: 32'd0});
        @(negedge CLK);
        check("sc_rep_no_wen", {31'd0, dmemWEN}, 32'd0);
        check("sc_rep_no_stall", {31'd0, m_stall}, 32'd0);
        step(); clr();

        // LL 0x200, snoop invalidate of 0x200, SC fails.
        set_load(OP_LL, 32'h200, 5'd5, 32'h7, 1'b1);
        exp_q.push_back('{wsel: 5'd5, wdat: 32'h7});
        step(); clr();
        ccinv = 1; ccsnoopaddr = 32'h200;
        step(); clr();
        set_store(OP_SC, 32'h200, 32'd9, 5'd6, 1'b1, 1'b0);
        exp_q.push_back('{wsel: 5'd6, wdat: 32'd0});
        @(negedge CLK);
        check("sc_snoop_no_wen", {31'd0, dmemWEN}, 32'd0);
        step(); clr();

        // LL 0x400, snoop of an unrelated word, SC succeeds with a same-cycle hit.
        set_load(OP_LL, 32'h400, 5'd5, 32'h7, 1'b1);
        exp_q.push_back('{wsel: 5'd5, wdat: 32'h7});
        step(); clr();
        ccinv = 1; ccsnoopaddr = 32'h800;
        step(); clr();
        set_store(OP_SC, 32'h400, 32'd3, 5'd6, 1'b1, 1'b1);
        exp_q.push_back('{wsel: 5'd6, wdat: 32'd1});
        @(negedge CLK);
        check("sc_other_snoop_wen", {31'd0, dmemWEN}, 32'd1);
        step(); clr();

        // LL 0x300, local SW to 0x300 clears the link, SC fails.
        set_load(OP_LL, 32'h300, 5'd5, 32'h7, 1'b1);
        exp_q.push_back('{wsel: 5'd5, wdat: 32'h7});
        step(); clr();
        set_store(OP_SW, 32'h300, 32'h11, 5'd0, 1'b0, 1'b1);
        step(); clr();
        set_store(OP_SC, 32'h300, 32'h22, 5'd6, 1'b1, 1'b0);
        exp_q.push_back('{wsel: 5'd6, wdat: 32'd0});
        @(negedge CLK);
        check("sc_after_sw_no_wen", {31'd0, dmemWEN}, 32'd0);
        step(); clr();

        // SW 0x40 flushed at cycle 2 before dhit: request drops, no write.
        set_store(OP_SW, 32'h40, 32'hAA, 5'd7, 1'b1, 1'b0);
        @(negedge CLK);
        check("sw_c1_wen", {31'd0, dmemWEN}, 32'd1);
        check("sw_c1_stall", {31'd0, m_stall}, 32'd1);
        step();
        flush = 1;
        @(negedge CLK);
        check("sw_flush_wen_held", {31'd0, dmemWEN}, 32'd1);
        step(); clr();
        @(negedge CLK);
        check("sw_flush_wen_dropped", {31'd0, dmemWEN}, 32'd0);
        check("sw_flush_no_stall", {31'd0, m_stall}, 32'd0);

        // LW with flush arriving together with dhit: op still completes.
        step();
        set_load(OP_LW, 32'h104, 5'd8, 32'h1234, 1'b0);
        exp_q.push_back('{wsel: 5'd8, wdat: 32'h1234});
        step();
        dhit = 1; flush = 1;
        @(negedge CLK);
        check("flush_hit_ren", {31'd0, dmemREN}, 32'd1);
        step(); clr();
        @(negedge CLK);
        check("stall_cnt_total", stall_cnt, 32'd7);

        // HALT: sticky, blocks later requests and writes.
        step();
        HALT_in = 1;
        step(); clr();
        @(negedge CLK);
        check("halt_set", {31'd0, HALT_out}, 32'd1);
        step();
        set_load(OP_LW, 32'h500, 5'd9, 32'h99, 1'b0);
        @(negedge CLK);
        check("halt_no_ren", {31'd0, dmemREN}, 32'd0);
        check("halt_no_stall", {31'd0, m_stall}, 32'd0);
        step(); clr();
        portO_in = 32'h77; WSel_in = 5'd10; WEN_in = 1;
        step(); clr();
        @(negedge CLK);
        check("halt_sticky", {31'd0, HALT_out}, 32'd1);

        // Reset clears halt; then reset in the middle of an access.
        RST = 1;
        step();
        RST = 0;
        @(negedge CLK);
        check("halt_cleared", {31'd0, HALT_out}, 32'd0);
        step();
        set_load(OP_LW, 32'h600, 5'd11, 32'h66, 1'b0);
        @(negedge CLK);
        check("rst_acc_ren", {31'd0, dmemREN}, 32'd1);
        step();
        RST = 1;
        step();
        RST = 0; clr();
        @(negedge CLK);
        check("rst_acc_ren_off", {31'd0, dmemREN}, 32'd0);
        check("rst_acc_stall_off", {31'd0, m_stall}, 32'd0);
        check("rst_acc_wen_out", {31'd0, WEN_out}, 32'd0);
        check("rst_acc_stall_cnt", stall_cnt, 32'd0);

        repeat (3) step();
        check("sb_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
